// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Parametrised UART transmitter with a small input FIFO. Upstream pushes words
// through a valid/ready handshake. The serialiser pops the FIFO head and sends
// start + DATA_BITS (LSB first) + optional parity + STOP_BITS stop bits. Each
// bit lasts CLK_FREQ/BAUD_RATE clocks. When a stop bit ends and the FIFO holds
// another word, the next start bit follows with no idle gap.
//
// Compile-time option: define UART_TX_PARITY_EN to build the parity state.
// PARITY then selects 0 = none, 1 = even or 2 = odd. Without the macro no
// parity logic exists and PARITY is ignored.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   in_valid    upstream word valid
//   in_data     upstream word, DATA_BITS wide
//   in_ready    FIFO can take a word (not full)
//   tx_pin      serial output, idle high, registered
//   busy        frame on the line or FIFO non-empty (registered)
//   fifo_level  current FIFO occupancy, 0..FIFO_DEPTH
//
// FSM states:
//   state    | meaning
//   S_IDLE   | line idle (high), waiting for a FIFO word
//   S_START  | start bit (low)
//   S_DATA   | payload bits, LSB first, bit index in bit_q
//   S_PARITY | parity bit (only with UART_TX_PARITY_EN)
//   S_STOP   | STOP_BITS stop bits (high), stop index in bit_q
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [DATA_BITS-1:0]            in_data,
  output logic                            in_ready,
  output logic                            tx_pin,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int CYCLE = CLK_FREQ / BAUD_RATE;
  localparam int CW    = (CYCLE > 2) ? $clog2(CYCLE) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int BW    = 4;

  if (CYCLE < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || PARITY < 0 || PARITY > 2)
  begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  localparam logic PAR_ON  = (PARITY == 1) || (PARITY == 2);
  localparam logic PAR_ODD = (PARITY == 2);
`endif

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        count_q, count_d;
  logic                 full_q;
  logic                 empty;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  // in_ready comes only from the registered full flag, so a pop in the same
  // cycle never lets a write through while full.
  assign in_ready   = !full_q;
  assign push       = in_valid && !full_q;
  assign empty      = (count_q == '0);
  assign head       = mem[rd_ptr_q];
  assign fifo_level = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == LW'(FIFO_DEPTH));
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign bit_end = (cyc_q == CW'(CYCLE - 1));
  assign tx_pin  = tx_q;
  assign busy    = busy_q;

  // State register. The datapath registers sit here as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= (state_q != S_IDLE) || (count_q != '0);
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PAR_ON ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Chain straight into the next frame when a word is waiting.
            if (!empty) begin
              pop     = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase
    // The payload is captured at pop, so later writes cannot disturb it.
    if (pop) shreg_d = head;
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    par_d = par_q;
    if (pop) par_d = (^head) ^ PAR_ODD;
  end
`endif

  // Output logic. tx is decoded from the next state so that the pin is a
  // clean flop output that changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Two instances share one clock: an 8N1 transmitter, and a 7-bit, 2-stop,
// odd-parity transmitter. The expected line of the second one depends on
// whether UART_TX_PARITY_EN is defined. A timeline model predicts tx_pin,
// fifo_level, in_ready and busy after every clock edge. The model keeps a
// queue of accepted words and a frame schedule; a frame starts at the first
// edge at which the line is free and a word is waiting.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int C     = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P1 = 2;
`else
  localparam int P1 = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v0, v1;
  logic [7:0] d0;
  logic [6:0] d1;
  logic       r0, r1, t0, t1, b0, b1;
  logic [2:0] l0, l1;

  uart_tx_fifo #(
    .CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8), .STOP_BITS(1),
    .FIFO_DEPTH(DEPTH), .PARITY(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_ready(r0),
    .tx_pin(t0), .busy(b0), .fifo_level(l0)
  );

  uart_tx_fifo #(
    .CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(7), .STOP_BITS(2),
    .FIFO_DEPTH(DEPTH), .PARITY(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(r1),
    .tx_pin(t1), .busy(b1), .fifo_level(l1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int     m_db[2] = '{8, 7};
  int     m_sb[2] = '{1, 2};
  int     m_pm[2] = '{0, P1};
  int     m_q0[$];
  int     m_q1[$];
  bit     m_act[2];
  longint m_start[2];
  longint m_end[2];
  int     m_bits[2][16];
  int     m_len[2];
  bit     p_act[2];
  int     p_cnt[2];
  longint t = 0;
  int     peak0 = 0;

  function automatic int m_cnt(input int k);
    return (k == 0) ? m_q0.size() : m_q1.size();
  endfunction

  task automatic m_reset(input int k);
    if (k == 0) m_q0.delete(); else m_q1.delete();
    m_act[k] = 1'b0;
    p_act[k] = 1'b0;
    p_cnt[k] = 0;
  endtask

  task automatic m_step(input int k, input bit v, input int d);
    bit free, dopop;
    int w, par, b, n;
    p_act[k] = m_act[k];
    p_cnt[k] = m_cnt(k);
    free  = !m_act[k] || (t == m_end[k]);
    dopop = free && (m_cnt(k) > 0);
    if (v && m_cnt(k) < DEPTH) begin
      if (k == 0) m_q0.push_back(d); else m_q1.push_back(d);
    end
    if (dopop) begin
      if (k == 0) w = m_q0.pop_front(); else w = m_q1.pop_front();
      n   = 0;
      par = 0;
      m_bits[k][n++] = 0;
      for (int i = 0; i < m_db[k]; i++) begin
        b = (w >> i) & 1;
        m_bits[k][n++] = b;
        par ^= b;
      end
      if (m_pm[k] != 0) m_bits[k][n++] = par ^ ((m_pm[k] == 2) ? 1 : 0);
      for (int i = 0; i < m_sb[k]; i++) m_bits[k][n++] = 1;
      m_len[k]   = n;
      m_start[k] = t;
      m_end[k]   = t + longint'(n * C);
      m_act[k]   = 1'b1;
    end else if (m_act[k] && t == m_end[k]) begin
      m_act[k] = 1'b0;
    end
  endtask

  function automatic int exp_tx(input int k);
    int idx;
    if (!m_act[k]) return 1;
    idx = int'((t - m_start[k]) / C);
    if (idx >= m_len[k]) return 1;
    return m_bits[k][idx];
  endfunction

  always begin
    @(posedge clk);
    t++;
    if (!rst_n) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(0, v0, int'(d0));
      m_step(1, v1, int'(d1));
    end
    #1;
    check("tx0",   int'(t0), exp_tx(0));
    check("lvl0",  int'(l0), m_cnt(0));
    check("rdy0",  int'(r0), int'(m_cnt(0) < DEPTH));
    check("busy0", int'(b0), int'(p_act[0] || p_cnt[0] != 0));
    check("tx1",   int'(t1), exp_tx(1));
    check("lvl1",  int'(l1), m_cnt(1));
    check("rdy1",  int'(r1), int'(m_cnt(1) < DEPTH));
    check("busy1", int'(b1), int'(p_act[1] || p_cnt[1] != 0));
    if (int'(l0) > peak0) peak0 = int'(l0);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (n < maxc && (b0 || b1 || l0 != 0 || l1 != 0)) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", int'(n < maxc), 1);
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] words [6];
  int         acc;
  int         guard;
  bit         rdy;
  bit         saw_full;

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    repeat (3) @(negedge clk);
    check("rst_tx0", int'(t0), 1);
    check("rst_busy0", int'(b0), 0);
    check("rst_lvl0", int'(l0), 0);
    check("rst_rdy0", int'(r0), 1);
    check("rst_tx1", int'(t1), 1);
    check("rst_rdy1", int'(r1), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single words: 8N1 0xA5 and 7-bit odd parity 0x41.
    v0 = 1'b1; d0 = 8'hA5; v1 = 1'b1; d1 = 7'h41;
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    wait_idle(2000);

    // Back-to-back frames.
    peak0 = 0;
    v0 = 1'b1; d0 = 8'h00; @(negedge clk);
    d0 = 8'hFF;            @(negedge clk);
    d0 = 8'h3C;            @(negedge clk);
    v0 = 1'b0;
    wait_idle(2000);
    check("peak_lvl", peak0, 2);

    // FIFO full: keep in_valid high with six words.
    for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
    acc = 0; guard = 0; saw_full = 1'b0;
    v0 = 1'b1;
    while (acc < 6 && guard < 3000) begin
      d0  = words[acc];
      rdy = r0;
      if (!rdy) saw_full = 1'b1;
      @(negedge clk);
      if (rdy) acc++;
      guard++;
    end
    v0 = 1'b0;
    check("full_accept", acc, 6);
    check("saw_full", int'(saw_full), 1);
    wait_idle(3000);

    // Reset during the 4th data bit of 0xA5 (that bit is 0).
    v0 = 1'b1; d0 = 8'hA5; @(negedge clk);
    d0 = 8'h3C;            @(negedge clk);
    v0 = 1'b0;
    repeat (42) @(posedge clk);
    #2;
    check("pre_rst_tx0", int'(t0), 0);
    check("pre_rst_lvl0", int'(l0), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_tx0", int'(t0), 1);
    check("async_lvl0", int'(l0), 0);
    check("async_busy0", int'(b0), 0);
    check("async_rdy0", int'(r0), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v0 = 1'b1; d0 = 8'h96; @(negedge clk);
    v0 = 1'b0;
    wait_idle(2000);

    // Random traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      v0 = ($urandom_range(0, 99) < 25);
      d0 = 8'($urandom);
      v1 = ($urandom_range(0, 99) < 10);
      d1 = 7'($urandom);
      @(negedge clk);
    end
    v0 = 1'b0; v1 = 1'b0;
    wait_idle(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
